// File: rtl/convolutional_layer_pkg.sv
// Shared constants for the streaming convolution layer: default geometry,
// sample widths, the fixed filter weight and the bench clock period.
package convolutional_layer_pkg;

    localparam int unsigned PERIOD          = 10;
    localparam int unsigned DEF_D_WIDTH     = 8;
    localparam int unsigned DEF_Q_WIDTH     = 16;
    localparam int unsigned DEF_D_CHANNELS  = 3;
    localparam int unsigned DEF_Q_CHANNELS  = 5;
    localparam int unsigned DEF_FILTER_SIZE = 5;
    localparam int unsigned DEF_IMAGE_SIZE  = 64;
    localparam int unsigned DEF_STRIDE      = 1;
    localparam int unsigned WEIGHT          = 1;

endpackage

// File: rtl/convolutional_layer_if.sv
// Pixel-in / result-out bundle of the convolution layer; the source drives
// clk_en and input_data, the layer returns output_data and valid.
interface convolutional_layer_if
    import convolutional_layer_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_D_CHANNELS * DEF_D_WIDTH,
    parameter int unsigned OUT_W = DEF_Q_CHANNELS * DEF_Q_WIDTH
);

    logic             clk_en;
    logic [IN_W-1:0]  input_data;
    logic [OUT_W-1:0] output_data;
    logic             valid;

    modport master (output clk_en, output input_data, input output_data, input valid);
    modport slave  (input clk_en, input input_data, output output_data, output valid);

endinterface

// File: rtl/convolutional_layer_conv_window_buffer.sv
// K-1 line buffers of one image row each feeding a KxK shift-register window;
// the window-ready flag travels with the window it describes.
module convolutional_layer_conv_window_buffer
    import convolutional_layer_pkg::*;
#(
    parameter int unsigned PIX_W = DEF_D_CHANNELS * DEF_D_WIDTH,
    parameter int unsigned K     = DEF_FILTER_SIZE,
    parameter int unsigned W     = DEF_IMAGE_SIZE,
    parameter int unsigned COL_W = $clog2(DEF_IMAGE_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_en,
    input  logic [COL_W-1:0]       i_col,
    input  logic [PIX_W-1:0]       i_pixel,
    input  logic                   i_win_ok,
    output logic [K*K*PIX_W-1:0]   o_window,
    output logic                   o_window_ready
);

    logic [PIX_W-1:0] r_line [K-1][W];
    logic [PIX_W-1:0] r_win  [K][K];
    logic [PIX_W-1:0] w_col  [K];
    logic             r_ready;

    // New window column: bottom entry is the incoming pixel, above it the same column of older rows
    always_comb begin
        for (int j = 0; j < K; j++) w_col[j] = '0;
        w_col[K-1] = i_pixel;
        for (int m = 1; m < K; m++) w_col[K-1-m] = r_line[m-1][i_col];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int m = 0; m < K-1; m++)
                for (int x = 0; x < W; x++) r_line[m][x] <= '0;
            for (int j = 0; j < K; j++)
                for (int k = 0; k < K; k++) r_win[j][k] <= '0;
            r_ready <= 1'b0;
        end else if (i_en) begin
            r_line[0][i_col] <= i_pixel;
            for (int m = 1; m < K-1; m++) r_line[m][i_col] <= r_line[m-1][i_col];
            for (int j = 0; j < K; j++) begin
                for (int k = 0; k < K-1; k++) r_win[j][k] <= r_win[j][k+1];
                r_win[j][K-1] <= w_col[j];
            end
            r_ready <= i_win_ok;
        end
    end

    always_comb begin
        o_window = '0;
        for (int j = 0; j < K; j++)
            for (int k = 0; k < K; k++) o_window[(j*K + k)*PIX_W +: PIX_W] = r_win[j][k];
    end

    assign o_window_ready = r_ready;

endmodule

// File: rtl/convolutional_layer.sv
// Streaming KxK unpadded convolution with unit weights: raster counters pick
// the windows to emit, one adder/output stage follows the window register.
module convolutional_layer
    import convolutional_layer_pkg::*;
#(
    parameter int unsigned D_WIDTH     = DEF_D_WIDTH,
    parameter int unsigned Q_WIDTH     = DEF_Q_WIDTH,
    parameter int unsigned D_CHANNELS  = DEF_D_CHANNELS,
    parameter int unsigned Q_CHANNELS  = DEF_Q_CHANNELS,
    parameter int unsigned FILTER_SIZE = DEF_FILTER_SIZE,
    parameter int unsigned IMAGE_SIZE  = DEF_IMAGE_SIZE,
    parameter int unsigned STRIDE      = DEF_STRIDE
) (
    input  logic                 clk,
    input  logic                 reset,
    convolutional_layer_if.slave io_bus
);

    localparam int unsigned PIX_W = D_CHANNELS * D_WIDTH;
    localparam int unsigned OUT_W = Q_CHANNELS * Q_WIDTH;
    localparam int unsigned TAPS  = FILTER_SIZE * FILTER_SIZE;
    localparam int unsigned COL_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int unsigned ROW_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int unsigned PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int unsigned ACC_W = D_WIDTH + $clog2(TAPS * D_CHANNELS + 1);

    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [PH_W-1:0]       r_col_ph;
    logic [PH_W-1:0]       r_row_ph;
    logic                  w_col_last;
    logic                  w_win_ok;
    logic [TAPS*PIX_W-1:0] w_window;
    logic                  w_ready;
    logic [ACC_W-1:0]      w_sum;
    logic [OUT_W-1:0]      w_out_data;
    logic [OUT_W-1:0]      r_out;
    logic                  r_valid;

    assign w_col_last = (r_col == COL_W'(IMAGE_SIZE - 1));
    assign w_win_ok   = (r_row == ROW_W'(FILTER_SIZE - 1)) && (r_col >= COL_W'(FILTER_SIZE - 1))
                        && (r_col_ph == '0) && (r_row_ph == '0);

    // Row counter saturates at K-1; phase counters track the stride offset once windows exist
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col    <= '0;
            r_row    <= '0;
            r_col_ph <= '0;
            r_row_ph <= '0;
        end else if (io_bus.clk_en) begin
            r_col <= w_col_last ? '0 : r_col + COL_W'(1);
            if (w_col_last || (r_col < COL_W'(FILTER_SIZE - 1)))
                r_col_ph <= '0;
            else
                r_col_ph <= (r_col_ph == PH_W'(STRIDE - 1)) ? '0 : r_col_ph + PH_W'(1);
            if (w_col_last) begin
                if (r_row != ROW_W'(FILTER_SIZE - 1)) begin
                    r_row    <= r_row + ROW_W'(1);
                    r_row_ph <= '0;
                end else begin
                    r_row_ph <= (r_row_ph == PH_W'(STRIDE - 1)) ? '0 : r_row_ph + PH_W'(1);
                end
            end
        end
    end

    convolutional_layer_conv_window_buffer #(
        .PIX_W (PIX_W),
        .K     (FILTER_SIZE),
        .W     (IMAGE_SIZE),
        .COL_W (COL_W)
    ) u_window (
        .clk            (clk),
        .reset          (reset),
        .i_en           (io_bus.clk_en),
        .i_col          (r_col),
        .i_pixel        (io_bus.input_data),
        .i_win_ok       (w_win_ok),
        .o_window       (w_window),
        .o_window_ready (w_ready)
    );

    always_comb begin
        w_sum = '0;
        for (int p = 0; p < TAPS; p++)
            for (int ch = 0; ch < D_CHANNELS; ch++)
                w_sum = w_sum + ACC_W'(w_window[(p*D_CHANNELS + ch)*D_WIDTH +: D_WIDTH] * WEIGHT);
    end

    assign w_out_data = {Q_CHANNELS{Q_WIDTH'(w_sum)}};

    // Output register keeps the last result while no new window completes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (io_bus.clk_en) begin
            r_valid <= w_ready;
            if (w_ready) r_out <= w_out_data;
        end
    end

    assign io_bus.output_data = r_out;
    assign io_bus.valid       = r_valid & io_bus.clk_en;

endmodule

// File: tb/tb_convolutional_layer.sv
// Bench for convolutional_layer: unit-stride and stride-2 instances share one
// pixel stream and are scored against a window-sum model of the image.
module tb_convolutional_layer;
    import convolutional_layer_pkg::*;

    localparam int WI    = DEF_IMAGE_SIZE;
    localparam int KI    = DEF_FILTER_SIZE;
    localparam int DW    = DEF_D_WIDTH;
    localparam int DC    = DEF_D_CHANNELS;
    localparam int QC    = DEF_Q_CHANNELS;
    localparam int QW    = DEF_Q_WIDTH;
    localparam int PIX_W = DC * DW;
    localparam int OUT_W = QC * QW;
    localparam int MAX_H = 33;

    typedef struct {
        int            idx;
        logic [QW-1:0] sum;
    } exp_t;

    typedef struct {
        logic [PIX_W-1:0] pix;
        logic [QW-1:0]    lane;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [PIX_W-1:0] img [MAX_H][WI];
    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   failures = 0;
    int   acc = 0;
    int   n_seen1, n_seen2, first_acc1;
    vec_t vecs[6];

    convolutional_layer_if #(.IN_W(PIX_W), .OUT_W(OUT_W)) bus1 ();
    convolutional_layer_if #(.IN_W(PIX_W), .OUT_W(OUT_W)) bus2 ();

    convolutional_layer u_dut1 (.clk(clk), .reset(reset), .io_bus(bus1));
    convolutional_layer #(.STRIDE(2)) u_dut2 (.clk(clk), .reset(reset), .io_bus(bus2));

    always #(PERIOD/2) clk = ~clk;

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected results: every unpadded window whose offset from (K-1,K-1) is a stride multiple
    function automatic void model(input int h);
        q1.delete();
        q2.delete();
        for (int r = KI - 1; r < h; r++)
            for (int c = KI - 1; c < WI; c++) begin
                exp_t e;
                int   total = 0;
                for (int dr = 0; dr < KI; dr++)
                    for (int dc = 0; dc < KI; dc++)
                        for (int ch = 0; ch < DC; ch++)
                            total += int'(img[r-dr][c-dc][ch*DW +: DW]);
                e.idx = r * WI + c;
                e.sum = QW'(total);
                q1.push_back(e);
                if (((r - (KI - 1)) % 2 == 0) && ((c - (KI - 1)) % 2 == 0)) q2.push_back(e);
            end
    endfunction

    task automatic check_lane(input int sel, input logic v, input logic en, input logic [OUT_W-1:0] d);
        exp_t e;
        bit   have;
        if (!v) return;
        check(sel == 1 ? "valid_gate_s1" : "valid_gate_s2", OUT_W'(en), OUT_W'(1));
        if (sel == 1) begin
            have = (q1.size() > 0);
            if (have) e = q1.pop_front();
            if (n_seen1 == 0) first_acc1 = acc;
            n_seen1++;
        end else begin
            have = (q2.size() > 0);
            if (have) e = q2.pop_front();
            n_seen2++;
        end
        if (!have) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid_s%0d actual=%0h required=no pending result", sel, d);
        end else begin
            check(sel == 1 ? "data_s1" : "data_s2", d, {QC{e.sum}});
            check(sel == 1 ? "latency_s1" : "latency_s2", OUT_W'(acc), OUT_W'(e.idx + 2));
        end
    endtask

    always @(posedge clk) begin
        if (reset) acc = 0;
        else if (bus1.clk_en) acc = acc + 1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            check_lane(1, bus1.valid, bus1.clk_en, bus1.output_data);
            check_lane(2, bus2.valid, bus2.clk_en, bus2.output_data);
        end
    end

    task automatic set_in(input logic en, input logic [PIX_W-1:0] d);
        bus1.clk_en     = en;
        bus2.clk_en     = en;
        bus1.input_data = d;
        bus2.input_data = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(1'b0, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q1.delete();
        q2.delete();
        n_seen1    = 0;
        n_seen2    = 0;
        first_acc1 = -1;
        set_in(1'b1, '0);
        #1;
        check("rst_valid_s1", OUT_W'(bus1.valid), '0);
        check("rst_data_s1", bus1.output_data, '0);
        check("rst_valid_s2", OUT_W'(bus2.valid), '0);
        check("rst_data_s2", bus2.output_data, '0);
        set_in(1'b0, '0);
    endtask

    task automatic stream(input int n_pix, input bit toggle);
        for (int p = 0; p < n_pix; p++) begin
            set_in(1'b1, img[p / WI][p % WI]);
            @(posedge clk);
            #1;
            if (toggle) begin
                set_in(1'b0, PIX_W'($urandom));
                @(posedge clk);
                #1;
            end
        end
        set_in(1'b0, '0);
    endtask

    // Full image plus two trailing pixels so the last result reaches the output
    task automatic run_image(input int h, input bit toggle, input int cnt1, input int cnt2);
        model(h);
        stream(h * WI + 2, toggle);
        check("count_s1", OUT_W'(n_seen1), OUT_W'(cnt1));
        check("count_s2", OUT_W'(n_seen2), OUT_W'(cnt2));
        check("drain_s1", OUT_W'(q1.size()), '0);
        check("drain_s2", OUT_W'(q2.size()), '0);
        check("first_valid_s1", OUT_W'(first_acc1), OUT_W'(4 * WI + 4 + 2));
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, '0);
        vecs[0] = '{pix: 24'h010101, lane: 16'd75};
        vecs[1] = '{pix: 24'hFFFFFF, lane: 16'd19125};
        vecs[2] = '{pix: 24'h000000, lane: 16'd0};
        vecs[3] = '{pix: 24'h010203, lane: 16'd150};
        vecs[4] = '{pix: 24'h808080, lane: 16'd9600};
        vecs[5] = '{pix: 24'hFF0000, lane: 16'd6375};
        repeat (2) @(posedge clk);

        // Constant images: every lane of every result is a known constant
        for (int v = 0; v < 6; v++) begin
            for (int r = 0; r < MAX_H; r++)
                for (int c = 0; c < WI; c++) img[r][c] = vecs[v].pix;
            do_reset();
            run_image(6, 1'b0, 120, 30);
            check("const_lane_s1", bus1.output_data, {QC{vecs[v].lane}});
            check("const_lane_s2", bus2.output_data, {QC{vecs[v].lane}});
        end

        // Random 64x32 image, continuous enable
        for (int r = 0; r < MAX_H; r++)
            for (int c = 0; c < WI; c++) img[r][c] = PIX_W'($urandom);
        do_reset();
        run_image(32, 1'b0, 1680, 420);

        // Ramp image with clk_en toggling every cycle
        for (int r = 0; r < MAX_H; r++)
            for (int c = 0; c < WI; c++) img[r][c] = {8'(r * WI + c), 8'(r + c), 8'(c)};
        do_reset();
        run_image(32, 1'b1, 1680, 420);

        // Reset in the middle of row 10, then the same image from the start
        for (int r = 0; r < MAX_H; r++)
            for (int c = 0; c < WI; c++) img[r][c] = PIX_W'($urandom);
        do_reset();
        model(32);
        stream(10 * WI + 21, 1'b0);
        do_reset();
        run_image(32, 1'b0, 1680, 420);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
